ball_ctl: RTL and testbench
===========================

# ball_ctl

Ball motion controller for the Pong datapath: the producer of the `x_position`/`y_position` pair that the ball overlay stage consumes. It holds the ball at screen centre until served, then advances it by a fixed step once per frame. It bounces the ball off the top and bottom walls and off both paddles, and reports a point when a paddle misses. It sits between the game-control logic (serve, paddle positions, frame tick) and the VGA draw chain.

## Interface
Parameters:
- `SCREEN_W`, 800: active width in pixels.
- `SCREEN_H`, 600: active height in pixels.
- `BALL_SIZE`, 10: ball covers x..x+BALL_SIZE and y..y+BALL_SIZE inclusive.
- `SPEED`, 4: pixels per frame on each axis.
- `PADDLE_W`, 10: paddle width; a paddle covers px..px+PADDLE_W.
- `PADDLE_H`, 80: paddle height; a paddle covers py..py+PADDLE_H.
- `LEFT_PADDLE_X`, 20: left paddle x.
- `RIGHT_PADDLE_X`, 770: right paddle x.
- `HOLD_FRAMES`, 60: frames the ball stays parked after a point.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, **synchronous, active-high**. The block has one clock only.
- `frame_tick` in 1: one-cycle pulse per frame, at vblank start.
- `serve` in 1: one-cycle pulse that launches the ball.
- `paddle_l_y` in 11: left paddle top y.
- `paddle_r_y` in 11: right paddle top y.
- `x_position` out 11: ball left x. Registered.
- `y_position` out 11: ball top y. Registered.
- `score_l` out 1: one-cycle pulse when the left player wins a point.
- `score_r` out 1: one-cycle pulse when the right player wins a point.
- `in_play` out 1: high while in state MOVE.

## Operation
Constants:
- X0 = (SCREEN_W-BALL_SIZE)/2 = 395.
- Y0 = (SCREEN_H-BALL_SIZE)/2 = 295.
- XMAX = SCREEN_W-1-BALL_SIZE = 789.
- YMAX = SCREEN_H-1-BALL_SIZE = 589.

State registers:
- `dir_x`: 1 = right.
- `dir_y`: 1 = down.
- `serve_dir`: direction for the next serve.
- Hold counter: `$clog2(HOLD_FRAMES+1)` bits.

States:
- **IDLE**: ball at (X0,Y0). On `serve`: set dir_x = serve_dir and go to MOVE. `frame_tick` is ignored in this state.
- **MOVE**: on each `frame_tick`, compute the candidate position nx = x±SPEED, ny = y±SPEED in 12-bit signed, so underflow is visible.
  - Vertical:
    - If ny<0: y=0, dir_y=1.
    - If ny>YMAX: y=YMAX, dir_y=0.
    - Otherwise y=ny.
  - Left paddle hit: requires all of the following.
    - dir_x=0.
    - x > LEFT_PADDLE_X+PADDLE_W.
    - nx ≤ LEFT_PADDLE_X+PADDLE_W.
    - y+BALL_SIZE ≥ paddle_l_y.
    - y ≤ paddle_l_y+PADDLE_H.
    - Result: x = LEFT_PADDLE_X+PADDLE_W+1 = 31, dir_x=1.
  - Right paddle hit, mirrored: requires all of the following.
    - dir_x=1.
    - x+BALL_SIZE < RIGHT_PADDLE_X.
    - nx+BALL_SIZE ≥ RIGHT_PADDLE_X.
    - Vertical overlap with paddle_r_y, using the same rule as the left paddle.
    - Result: x = RIGHT_PADDLE_X-BALL_SIZE-1 = 759, dir_x=0.
  - Miss:
    - If nx<0: pulse `score_r` and set serve_dir=0, so the serve goes toward the loser.
    - If nx>XMAX: pulse `score_l` and set serve_dir=1.
    - In both cases: x=X0, y=Y0, load hold=HOLD_FRAMES, go to SCORED.
  - Otherwise x=nx.
  - The vertical and horizontal rules apply independently in the same tick (corner hits are allowed).
  - Paddle positions are sampled on the tick cycle.
- **SCORED**: ball parked at (X0,Y0).
  - Each `frame_tick` decrements hold.
  - The tick that reaches 0 moves the FSM to IDLE.
  - `serve` is ignored.

Other rules:
- `serve` in MOVE is ignored.
- `serve` and `frame_tick` in the same cycle while in IDLE: the serve is taken, no motion that cycle, and the first step happens on the next tick.
- All comparisons use 12-bit values; paddle inputs are zero-extended.

## Timing
- Reset values:
  - x_position=395, y_position=295.
  - score_l=score_r=0, in_play=0.
  - State IDLE.
  - dir_x=1, dir_y=1, serve_dir=1, hold=0.
- Reset mid-operation overrides everything, including a pending score pulse.
- Latency:
  - A position update is visible on the cycle after `frame_tick` (1 clk).
  - `score_*` is high for exactly that one cycle.
  - `in_play` goes high the cycle after `serve` and falls in the same cycle as the score pulse.
- `frame_tick` is assumed to be at least 2 cycles apart; consecutive ticks are each processed.

## Structure
- Shared package, the game package alongside `vga_pkg`, holds:
  - `ball_state_t` enum: IDLE, MOVE, SCORED.
  - Screen and paddle geometry constants, which draw stages also need.
- Optional sub-module `ball_axis_step`: combinational one-axis step, clamp and reflect, instantiated for y. The x axis needs the paddle and miss logic, so it stays inline.
- FSM: `always_ff` with `*_nxt` computed in `always_comb`.

## Test plan
- Reset, then 5 frame_ticks with no serve → position stays (395,295), in_play=0, no score pulses.
- serve, then frame_tick → (399,299), in_play=1. A second tick → (403,303).
- Force MOVE with y=2, dir_y=0, then frame_tick → y=0, dir_y=1. Next tick → y=4.
- x=757, dir_x=1, y=300, paddle_r_y=280, frame_tick → x=759, dir_x=0. Next tick → x=755.
- Same setup with paddle_r_y=0 → ball continues until nx>789, then score_l pulses for exactly 1 cycle. State SCORED, ball at (395,295). serve is ignored. After 60 ticks → IDLE. Next serve moves the ball right.
- rst asserted mid-MOVE at (500,100) → the next cycle shows (395,295), IDLE, in_play=0. A simultaneous serve+tick in IDLE → no motion that cycle, step on the following tick.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared game geometry and ball FSM state encoding, used by the ball
// controller and by the draw stages that render the paddles and ball.
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SCORED
  } ball_state_t;

  localparam int GEO_SCREEN_W       = 800;
  localparam int GEO_SCREEN_H       = 600;
  localparam int GEO_BALL_SIZE      = 10;
  localparam int GEO_SPEED          = 4;
  localparam int GEO_PADDLE_W       = 10;
  localparam int GEO_PADDLE_H       = 80;
  localparam int GEO_LEFT_PADDLE_X  = 20;
  localparam int GEO_RIGHT_PADDLE_X = 770;
  localparam int GEO_HOLD_FRAMES    = 60;

endpackage

// File: rtl/ball_axis_step.sv
// One-axis ball step: advance by SPEED, clamp to [0,MAX] and reflect the
// direction when a wall is crossed.
module ball_axis_step #(
  parameter int SPEED = 4,
  parameter int MAX   = 589
) (
  input  logic [10:0] i_pos,
  input  logic        i_dir,
  output logic [10:0] o_pos,
  output logic        o_dir
);
  localparam logic signed [11:0] C_SPD = 12'(SPEED);
  localparam logic signed [11:0] C_MAX = 12'(MAX);

  logic signed [11:0] w_pos;
  logic signed [11:0] w_n;

  // 12-bit signed so a step past zero shows up as negative
  assign w_pos = $signed({1'b0, i_pos});
  assign w_n   = i_dir ? w_pos + C_SPD : w_pos - C_SPD;

  always_comb begin
    o_pos = w_n[10:0];
    o_dir = i_dir;
    if (w_n < 0) begin
      o_pos = '0;
      o_dir = 1'b1;
    end else if (w_n > C_MAX) begin
      o_pos = C_MAX[10:0];
      o_dir = 1'b0;
    end
  end

endmodule

// File: rtl/ball_ctl.sv
// Ball motion controller: parks the ball at centre, moves it once per frame
// after a serve, bounces off walls and paddles, and pulses a score on a miss.
module ball_ctl
  import ball_pkg::*;
#(
  parameter int SCREEN_W       = GEO_SCREEN_W,
  parameter int SCREEN_H       = GEO_SCREEN_H,
  parameter int BALL_SIZE      = GEO_BALL_SIZE,
  parameter int SPEED          = GEO_SPEED,
  parameter int PADDLE_W       = GEO_PADDLE_W,
  parameter int PADDLE_H       = GEO_PADDLE_H,
  parameter int LEFT_PADDLE_X  = GEO_LEFT_PADDLE_X,
  parameter int RIGHT_PADDLE_X = GEO_RIGHT_PADDLE_X,
  parameter int HOLD_FRAMES    = GEO_HOLD_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        serve,
  input  logic [10:0] paddle_l_y,
  input  logic [10:0] paddle_r_y,
  output logic [10:0] x_position,
  output logic [10:0] y_position,
  output logic        score_l,
  output logic        score_r,
  output logic        in_play
);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [10:0]        C_X0    = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [10:0]        C_Y0    = 11'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic signed [11:0] C_XMAX  = 12'(SCREEN_W - 1 - BALL_SIZE);
  localparam int                 YMAX    = SCREEN_H - 1 - BALL_SIZE;
  localparam logic signed [11:0] C_SPD   = 12'(SPEED);
  localparam logic signed [11:0] C_BS    = 12'(BALL_SIZE);
  localparam logic signed [11:0] C_PH    = 12'(PADDLE_H);
  localparam logic signed [11:0] C_LEDGE = 12'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic signed [11:0] C_RPX   = 12'(RIGHT_PADDLE_X);
  localparam logic [10:0]        C_XL    = 11'(LEFT_PADDLE_X + PADDLE_W + 1);
  localparam logic [10:0]        C_XR    = 11'(RIGHT_PADDLE_X - BALL_SIZE - 1);
  localparam logic [HW-1:0]      C_HOLD  = HW'(HOLD_FRAMES);
  localparam logic [HW-1:0]      C_ONE   = HW'(1);

  ball_state_t r_state, w_state_nxt;
  logic [10:0] r_x, r_y, w_x_nxt, w_y_nxt, w_ystep;
  logic r_dir_x, r_dir_y, r_serve_dir;
  logic w_dir_x_nxt, w_dir_y_nxt, w_serve_dir_nxt, w_dir_ystep;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic r_score_l, r_score_r, w_score_l_nxt, w_score_r_nxt;

  logic signed [11:0] w_x12, w_y12, w_nx, w_pl, w_pr;
  logic w_ovl_l, w_ovl_r, w_hit_l, w_hit_r;

  ball_axis_step #(.SPEED(SPEED), .MAX(YMAX)) u_ystep (
    .i_pos (r_y),
    .i_dir (r_dir_y),
    .o_pos (w_ystep),
    .o_dir (w_dir_ystep)
  );

  assign w_x12 = $signed({1'b0, r_x});
  assign w_y12 = $signed({1'b0, r_y});
  assign w_pl  = $signed({1'b0, paddle_l_y});
  assign w_pr  = $signed({1'b0, paddle_r_y});
  assign w_nx  = r_dir_x ? w_x12 + C_SPD : w_x12 - C_SPD;

  // Hits need the ball to cross the paddle face this tick, not sit behind it
  assign w_ovl_l = (w_y12 + C_BS >= w_pl) && (w_y12 <= w_pl + C_PH);
  assign w_ovl_r = (w_y12 + C_BS >= w_pr) && (w_y12 <= w_pr + C_PH);
  assign w_hit_l = !r_dir_x && (w_x12 > C_LEDGE) && (w_nx <= C_LEDGE) && w_ovl_l;
  assign w_hit_r = r_dir_x && (w_x12 + C_BS < C_RPX) && (w_nx + C_BS >= C_RPX) && w_ovl_r;

  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_dir_x_nxt     = r_dir_x;
    w_dir_y_nxt     = r_dir_y;
    w_serve_dir_nxt = r_serve_dir;
    w_hold_nxt      = r_hold;
    w_score_l_nxt   = 1'b0;
    w_score_r_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_x_nxt = C_X0;
        w_y_nxt = C_Y0;
        if (serve) begin
          w_dir_x_nxt = r_serve_dir;
          w_state_nxt = MOVE;
        end
      end
      MOVE: begin
        if (frame_tick) begin
          w_y_nxt     = w_ystep;
          w_dir_y_nxt = w_dir_ystep;
          if (w_hit_l) begin
            w_x_nxt     = C_XL;
            w_dir_x_nxt = 1'b1;
          end else if (w_hit_r) begin
            w_x_nxt     = C_XR;
            w_dir_x_nxt = 1'b0;
          end else if (w_nx < 0 || w_nx > C_XMAX) begin
            // the serve after a point goes toward the player who lost it
            w_score_r_nxt   = (w_nx < 0);
            w_score_l_nxt   = (w_nx >= 0);
            w_serve_dir_nxt = (w_nx >= 0);
            w_x_nxt         = C_X0;
            w_y_nxt         = C_Y0;
            w_hold_nxt      = C_HOLD;
            w_state_nxt     = SCORED;
          end else begin
            w_x_nxt = w_nx[10:0];
          end
        end
      end
      SCORED: begin
        w_x_nxt = C_X0;
        w_y_nxt = C_Y0;
        if (frame_tick) begin
          if (r_hold <= C_ONE) begin
            w_hold_nxt  = '0;
            w_state_nxt = IDLE;
          end else begin
            w_hold_nxt = r_hold - C_ONE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= C_X0;
      r_y         <= C_Y0;
      r_dir_x     <= 1'b1;
      r_dir_y     <= 1'b1;
      r_serve_dir <= 1'b1;
      r_hold      <= '0;
      r_score_l   <= 1'b0;
      r_score_r   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_dir_x     <= w_dir_x_nxt;
      r_dir_y     <= w_dir_y_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_hold      <= w_hold_nxt;
      r_score_l   <= w_score_l_nxt;
      r_score_r   <= w_score_r_nxt;
    end
  end

  assign x_position = r_x;
  assign y_position = r_y;
  assign score_l    = r_score_l;
  assign score_r    = r_score_r;
  assign in_play    = (r_state == MOVE);

endmodule

// File: tb/tb_ball_ctl.sv
// Scoreboard bench for ball_ctl: a behavioural game model pushes the expected
// outputs for every driven cycle; each test pops and compares them.
module tb_ball_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        serve = 1'b0;
  logic [10:0] paddle_l_y = '0;
  logic [10:0] paddle_r_y = '0;
  logic [10:0] x_position, y_position;
  logic        score_l, score_r, in_play;

  ball_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .serve      (serve),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .x_position (x_position),
    .y_position (y_position),
    .score_l    (score_l),
    .score_r    (score_r),
    .in_play    (in_play)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit sl;
    bit sr;
    bit ip;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int m_x, m_y, m_dx, m_dy, m_sd, m_hold, m_st;
  bit l_far, r_far;

  task automatic model_reset();
    m_x = 395; m_y = 295; m_dx = 1; m_dy = 1; m_sd = 1; m_hold = 0; m_st = 0;
    sb.delete();
  endtask

  // Game behaviour straight from the description of the block
  task automatic model(input bit t, input bit s);
    int nx, ny, oy, pl, pr;
    exp_t e;
    bit sl, sr;
    sl = 0; sr = 0;
    pl = int'(paddle_l_y);
    pr = int'(paddle_r_y);
    case (m_st)
      0: if (s) begin m_dx = m_sd; m_st = 1; end
      1: if (t) begin
        oy = m_y;
        nx = (m_dx != 0) ? m_x + 4 : m_x - 4;
        ny = (m_dy != 0) ? m_y + 4 : m_y - 4;
        if (ny < 0) begin m_y = 0; m_dy = 1; end
        else if (ny > 589) begin m_y = 589; m_dy = 0; end
        else m_y = ny;
        if (m_dx == 0 && m_x > 30 && nx <= 30 && oy + 10 >= pl && oy <= pl + 80) begin
          m_x = 31; m_dx = 1;
        end else if (m_dx != 0 && m_x + 10 < 770 && nx + 10 >= 770 && oy + 10 >= pr && oy <= pr + 80) begin
          m_x = 759; m_dx = 0;
        end else if (nx < 0 || nx > 789) begin
          if (nx < 0) begin sr = 1; m_sd = 0; end
          else begin sl = 1; m_sd = 1; end
          m_x = 395; m_y = 295; m_hold = 60; m_st = 2;
        end else m_x = nx;
      end
      default: if (t) begin
        m_hold--;
        if (m_hold == 0) m_st = 0;
      end
    endcase
    e.x = m_x; e.y = m_y; e.sl = sl; e.sr = sr; e.ip = (m_st == 1);
    sb.push_back(e);
  endtask

  // Drive one cycle of tick/serve (ticks always >= 2 cycles apart), sample #1 after the edge
  task automatic step(input bit t, input bit s);
    @(posedge clk);
    @(negedge clk);
    paddle_l_y = l_far ? 11'd1000 : 11'(m_y);
    paddle_r_y = r_far ? 11'd1000 : 11'(m_y);
    frame_tick = t;
    serve      = s;
    model(t, s);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    serve      = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++;
    if (x_position !== 11'd395 || y_position !== 11'd295) begin
      bad++; $display("FAIL reset_pos: got (%0d,%0d) want (395,295)", x_position, y_position);
    end
    total++;
    if (in_play !== 1'b0 || score_l !== 1'b0 || score_r !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got ip=%b sl=%b sr=%b want 0 0 0", in_play, score_l, score_r);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      e = sb.pop_front();
      total++;
      if (x_position !== 11'(e.x) || y_position !== 11'(e.y) || score_l !== e.sl || score_r !== e.sr || in_play !== e.ip) begin
        bad++; $display("FAIL idle_tick%0d: got (%0d,%0d,%b%b%b) want (%0d,%0d,%b%b%b)", i,
          x_position, y_position, score_l, score_r, in_play, e.x, e.y, e.sl, e.sr, e.ip);
      end
    end
  endtask

  task automatic test_serve();
    exp_t e;
    l_far = 0; r_far = 0;
    for (int i = 0; i < 3; i++) begin
      step(i != 0, i == 0);
      e = sb.pop_front();
      total++;
      if (x_position !== 11'(e.x) || y_position !== 11'(e.y) || score_l !== e.sl || score_r !== e.sr || in_play !== e.ip) begin
        bad++; $display("FAIL serve_step%0d: got (%0d,%0d,%b%b%b) want (%0d,%0d,%b%b%b)", i,
          x_position, y_position, score_l, score_r, in_play, e.x, e.y, e.sl, e.sr, e.ip);
      end
    end
    total++;
    if (x_position !== 11'd403 || y_position !== 11'd303 || in_play !== 1'b1) begin
      bad++; $display("FAIL serve_2ticks: got (%0d,%0d) ip=%b want (403,303) ip=1", x_position, y_position, in_play);
    end
  endtask

  // Both paddles follow the ball: exercises both paddle bounces and both walls
  task automatic test_bounce();
    exp_t e;
    int prev_y = -1;
    bit done = 0;
    l_far = 0; r_far = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      step(1, 0);
      e = sb.pop_front();
      total++;
      if (x_position !== 11'(e.x) || y_position !== 11'(e.y) || score_l !== e.sl || score_r !== e.sr || in_play !== e.ip) begin
        bad++; $display("FAIL bounce_tick%0d: got (%0d,%0d,%b%b%b) want (%0d,%0d,%b%b%b)", i,
          x_position, y_position, score_l, score_r, in_play, e.x, e.y, e.sl, e.sr, e.ip);
      end
      if (prev_y == 0) begin
        total++;
        if (y_position !== 11'd4) begin
          bad++; $display("FAIL top_wall_rebound: got y=%0d want 4", y_position);
        end
        done = 1;
      end
      prev_y = int'(y_position);
    end
    if (!done) begin
      total++; bad++; $display("FAIL bounce_timeout: top wall never reached");
    end
  endtask

  // One side's paddle moved out of reach; ball scores, holds 60 frames, re-serves
  task automatic test_miss(input bit right_miss);
    exp_t e;
    bit done = 0;
    l_far = right_miss ? 1'b0 : 1'b1;
    r_far = right_miss;
    for (int i = 0; i < 400 && !done; i++) begin
      step(1, 0);
      e = sb.pop_front();
      total++;
      if (x_position !== 11'(e.x) || y_position !== 11'(e.y) || score_l !== e.sl || score_r !== e.sr || in_play !== e.ip) begin
        bad++; $display("FAIL miss_tick%0d: got (%0d,%0d,%b%b%b) want (%0d,%0d,%b%b%b)", i,
          x_position, y_position, score_l, score_r, in_play, e.x, e.y, e.sl, e.sr, e.ip);
      end
      if (e.sl || e.sr) done = 1;
    end
    total++;
    if (!done || score_l !== right_miss || score_r !== !right_miss || in_play !== 1'b0) begin
      bad++; $display("FAIL score_pulse: got sl=%b sr=%b ip=%b want sl=%b sr=%b ip=0",
        score_l, score_r, in_play, right_miss, !right_miss);
    end
    @(posedge clk);
    #1;
    total++;
    if (score_l !== 1'b0 || score_r !== 1'b0 || x_position !== 11'd395 || y_position !== 11'd295) begin
      bad++; $display("FAIL score_one_cycle: got sl=%b sr=%b (%0d,%0d) want 0 0 (395,295)",
        score_l, score_r, x_position, y_position);
    end
    // serve during hold is ignored; 59th tick still holds, 60th returns to IDLE
    for (int i = 0; i < 63; i++) begin
      if (i == 0 || i == 60 || i == 62) step(0, 1);
      else step(1, 0);
      e = sb.pop_front();
      total++;
      if (x_position !== 11'(e.x) || y_position !== 11'(e.y) || score_l !== e.sl || score_r !== e.sr || in_play !== e.ip) begin
        bad++; $display("FAIL hold_step%0d: got (%0d,%0d,%b%b%b) want (%0d,%0d,%b%b%b)", i,
          x_position, y_position, score_l, score_r, in_play, e.x, e.y, e.sl, e.sr, e.ip);
      end
    end
    step(1, 0);
    e = sb.pop_front();
    total++;
    if (x_position !== (right_miss ? 11'd399 : 11'd391) || in_play !== 1'b1 || x_position !== 11'(e.x)) begin
      bad++; $display("FAIL reserve_dir: got x=%0d ip=%b want x=%0d ip=1", x_position, in_play,
        right_miss ? 399 : 391);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    l_far = 0; r_far = 0;
    repeat (3) begin
      step(1, 0);
      void'(sb.pop_front());
    end
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame_tick = 1'b0;
    model_reset();
    total++;
    if (x_position !== 11'd395 || y_position !== 11'd295 || in_play !== 1'b0 || score_l !== 1'b0 || score_r !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got (%0d,%0d) ip=%b want (395,295) ip=0", x_position, y_position, in_play);
    end
    // serve and tick together from IDLE: serve taken, first step on the next tick
    for (int i = 0; i < 2; i++) begin
      step(1, i == 0);
      e = sb.pop_front();
      total++;
      if (x_position !== 11'(e.x) || y_position !== 11'(e.y) || score_l !== e.sl || score_r !== e.sr || in_play !== e.ip) begin
        bad++; $display("FAIL serve_tick%0d: got (%0d,%0d,%b%b%b) want (%0d,%0d,%b%b%b)", i,
          x_position, y_position, score_l, score_r, in_play, e.x, e.y, e.sl, e.sr, e.ip);
      end
    end
    total++;
    if (x_position !== 11'd399 || y_position !== 11'd299) begin
      bad++; $display("FAIL serve_tick_first_step: got (%0d,%0d) want (399,299)", x_position, y_position);
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_bounce();
    test_miss(1'b1);
    test_miss(1'b0);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
